mc_maindec: RTL and testbench
=============================

# mc_maindec

Multicycle main controller for the MIPS core: a Moore state machine that sequences fetch, decode, execute, memory and write-back over several cycles per instruction. It sequences one shared ALU and one unified instruction/data memory port, replacing the single-cycle combinational decoder in the multicycle datapath. Parameters add an optional memory ready/wait handshake and optional extended opcodes (BNE, ANDI, ORI, JAL). All datapath enables and mux selects are driven from the current state and the opcode held in the instruction register.

## Interface
- EXT_OPS, 1: 1 enables BNE (000101), ANDI (001100), ORI (001101) and JAL (000011); 0 treats these opcodes as illegal.
- MEM_HANDSHAKE, 0: 1 holds the memory states until mem_ready=1; 0 ignores mem_ready, so each memory state lasts one cycle.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  6  opcode from the instruction register; stable from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- mem_req  out  1  memory access requested.
- memwrite  out  1  memory write strobe.
- irwrite  out  1  instruction register load.
- regwrite  out  1  register file write.
- pcen  out  1  PC load: pcwrite | (branch & zero) | (bne & ~zero).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memtoreg  out  1  write-back select: 1 = memory data.
- regdst  out  1  destination register select: 1 = rd.
- link  out  1  write PC+4 into register $31.
- zeroext  out  1  zero-extend the immediate.
- alusrca  out  1  ALU A select: 0 = PC, 1 = rs.
- alusrcb  out  2  ALU B select: 00 = rt, 01 = 4, 10 = imm, 11 = imm<<2.
- pcsrc  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- aluop  out  3  ALU operation: 000 add, 001 sub, 010 funct, 011 and, 100 or.
- state_o  out  4  current state, for debug.
- illegal  out  1  one-cycle pulse on an unrecognised opcode.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXEC=6, ALUWB=7, BEQ=8, IMMEXEC=9, IMMWB=10, JUMP=11, BNE=12, JAL=13.
- Unlisted outputs are 0 in every state.
- FETCH: mem_req, iord=0, alusrcb=01, aluop=add. irwrite and pcwrite are gated by readiness (mem_ready, or always when MEM_HANDSHAKE=0). Goes to DECODE when ready, otherwise stays.
- DECODE: alusrcb=11, aluop=add. Next state by op:
  - 000000 -> RTEXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BEQ
  - 001000 -> IMMEXEC
  - 000010 -> JUMP
  - with EXT_OPS: 000101 -> BNE, 001100 or 001101 -> IMMEXEC, 000011 -> JAL
  - anything else -> FETCH with illegal=1.
- MEMADR: alusrca=1, alusrcb=10, aluop=add. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD: mem_req, iord=1. Goes to MEMWB when ready.
- MEMWB: regwrite, memtoreg=1, regdst=0. Goes to FETCH.
- MEMWR: mem_req, iord=1, memwrite. Goes to FETCH when ready; memwrite stays asserted for the whole wait.
- RTEXEC: alusrca=1, alusrcb=00, aluop=funct. Goes to ALUWB.
- ALUWB: regwrite, regdst=1. Goes to FETCH.
- BEQ and BNE: alusrca=1, alusrcb=00, aluop=sub, pcsrc=01. branch (or bne) is asserted internally. Goes to FETCH.
- IMMEXEC: alusrca=1, alusrcb=10. aluop is add for ADDI, and for ANDI, or for ORI; zeroext=1 for ANDI and ORI. Goes to IMMWB.
- IMMWB: regwrite, regdst=0, memtoreg=0. Goes to FETCH.
- JUMP: pcsrc=10, pcwrite. Goes to FETCH.
- JAL: pcsrc=10, pcwrite, regwrite, link. Goes to FETCH.

## Timing
- Outputs are Moore, decoded from the state register plus op and zero; there is no registered output latency.
- Cycle counts with no wait states:
  - R-type 4, LW 5, SW 4, ADDI/ANDI/ORI 4
  - BEQ/BNE 3, J/JAL 3
  - illegal opcode 2
- With MEM_HANDSHAKE=1, each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- Reset: when rst_n falls, state goes to FETCH immediately, regardless of clk.
  - While rst_n=0, pcen, irwrite, regwrite, memwrite, mem_req and illegal are forced to 0; state_o=0.
  - The first FETCH request is issued in the first cycle after rst_n rises.
- Reset mid-instruction abandons the instruction; no write strobe is asserted after rst_n falls.
- illegal is high only during the DECODE cycle and never asserts twice for the same instruction.

## Test plan
- Reset with MEM_HANDSHAKE=0, then op=100011 held -> states 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4; pcen=1 and irwrite=1 only in state 0.
- MEM_HANDSHAKE=1, SW with mem_ready low for 3 cycles in MEMWR -> memwrite=1 for 4 cycles, then FETCH. FETCH with mem_ready low for 2 cycles -> irwrite=0 until the ready cycle.
- BEQ with zero=1 -> pcen=1 and pcsrc=01 in state 8. BEQ with zero=0 -> pcen=0. BNE repeats both cases with pcen inverted.
- EXT_OPS=1, op=001101 -> aluop=100 and zeroext=1 in state 9. EXT_OPS=0, same op -> illegal pulse in DECODE, FETCH next, no regwrite.
- JAL -> state 13 with pcsrc=10, pcen=1, regwrite=1 and link=1, then FETCH. rst_n dropped asynchronously in state 3 -> state_o=0 and strobes 0 before the next clk edge.

Source files
------------

// File: rtl/mc_maindec.sv
// Multicycle MIPS main controller: Moore FSM stepping fetch, decode, execute,
// memory and write-back, driving datapath enables and mux selects from state and op.
module mc_maindec #(
   parameter bit EXT_OPS       = 1'b1,
   parameter bit MEM_HANDSHAKE = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regwrite,
   output logic       pcen,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic       link,
   output logic       zeroext,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] aluop,
   output logic [3:0] state_o,
   output logic       illegal
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_FUNCT = 3'b010;
   localparam logic [2:0] ALU_AND   = 3'b011;
   localparam logic [2:0] ALU_OR    = 3'b100;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTEXEC  = 4'd6,
      S_ALUWB   = 4'd7,
      S_BEQ     = 4'd8,
      S_IMMEXEC = 4'd9,
      S_IMMWB   = 4'd10,
      S_JUMP    = 4'd11,
      S_BNE     = 4'd12,
      S_JAL     = 4'd13
   } state_t;

   state_t state, state_next;

   logic ready;
   logic is_andi, is_ori, is_bne, is_jal;
   logic pcwrite, branch, bne, irwrite_raw, regwrite_raw, memwrite_raw, mem_req_raw, illegal_raw;

   // Without the handshake every memory state completes in a single cycle.
   assign ready   = MEM_HANDSHAKE ? mem_ready : 1'b1;
   assign is_andi = EXT_OPS && (op == OP_ANDI);
   assign is_ori  = EXT_OPS && (op == OP_ORI);
   assign is_bne  = EXT_OPS && (op == OP_BNE);
   assign is_jal  = EXT_OPS && (op == OP_JAL);

   always_comb begin
      state_next = state;
      case (state)
         S_FETCH:   if (ready) state_next = S_DECODE;
         S_DECODE: begin
            if (op == OP_RTYPE)                    state_next = S_RTEXEC;
            else if (op == OP_LW || op == OP_SW)   state_next = S_MEMADR;
            else if (op == OP_BEQ)                 state_next = S_BEQ;
            else if (op == OP_ADDI)                state_next = S_IMMEXEC;
            else if (op == OP_J)                   state_next = S_JUMP;
            else if (is_bne)                       state_next = S_BNE;
            else if (is_andi || is_ori)            state_next = S_IMMEXEC;
            else if (is_jal)                       state_next = S_JAL;
            else                                   state_next = S_FETCH;
         end
         S_MEMADR:  state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   if (ready) state_next = S_MEMWB;
         S_MEMWR:   if (ready) state_next = S_FETCH;
         S_RTEXEC:  state_next = S_ALUWB;
         S_IMMEXEC: state_next = S_IMMWB;
         default:   state_next = S_FETCH;
      endcase
   end

   // NOTE: state is the only register; non-blocking keeps it race-free against readers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_FETCH;
      else        state <= state_next;
   end

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      pcwrite      = 1'b0;
      branch       = 1'b0;
      bne          = 1'b0;
      irwrite_raw  = 1'b0;
      regwrite_raw = 1'b0;
      memwrite_raw = 1'b0;
      mem_req_raw  = 1'b0;
      illegal_raw  = 1'b0;
      iord         = 1'b0;
      memtoreg     = 1'b0;
      regdst       = 1'b0;
      link         = 1'b0;
      zeroext      = 1'b0;
      alusrca      = 1'b0;
      alusrcb      = 2'b00;
      pcsrc        = 2'b00;
      aluop        = ALU_ADD;
      case (state)
         S_FETCH: begin
            mem_req_raw = 1'b1;
            alusrcb     = 2'b01;
            irwrite_raw = ready;
            pcwrite     = ready;
         end
         S_DECODE: begin
            alusrcb     = 2'b11;
            illegal_raw = (state_next == S_FETCH);
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD: begin
            mem_req_raw = 1'b1;
            iord        = 1'b1;
         end
         S_MEMWB: begin
            regwrite_raw = 1'b1;
            memtoreg     = 1'b1;
         end
         S_MEMWR: begin
            mem_req_raw  = 1'b1;
            iord         = 1'b1;
            memwrite_raw = 1'b1;
         end
         S_RTEXEC: begin
            alusrca = 1'b1;
            aluop   = ALU_FUNCT;
         end
         S_ALUWB: begin
            regwrite_raw = 1'b1;
            regdst       = 1'b1;
         end
         S_BEQ, S_BNE: begin
            alusrca = 1'b1;
            aluop   = ALU_SUB;
            pcsrc   = 2'b01;
            branch  = (state == S_BEQ);
            bne     = (state == S_BNE);
         end
         S_IMMEXEC: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            zeroext = is_andi || is_ori;
            if (is_andi)     aluop = ALU_AND;
            else if (is_ori) aluop = ALU_OR;
         end
         S_IMMWB:   regwrite_raw = 1'b1;
         S_JUMP: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         S_JAL: begin
            pcsrc        = 2'b10;
            pcwrite      = 1'b1;
            regwrite_raw = 1'b1;
            link         = 1'b1;
         end
         default: ;
      endcase
   end

   // Strobes are masked by rst_n directly so nothing fires while reset is held.
   assign pcen     = rst_n & (pcwrite | (branch & zero) | (bne & ~zero));
   assign irwrite  = rst_n & irwrite_raw;
   assign regwrite = rst_n & regwrite_raw;
   assign memwrite = rst_n & memwrite_raw;
   assign mem_req  = rst_n & mem_req_raw;
   assign illegal  = rst_n & illegal_raw;
   assign state_o  = state;

endmodule

// File: tb/tb_mc_maindec.sv
// Scoreboard bench for mc_maindec: directed per-cycle expectations are queued by the
// stimulus and compared by a monitor against one of three parameter variants.
module tb_mc_maindec;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] op;
   logic       zero;
   logic       mem_ready;

   logic       mem_req[3], memwrite[3], irwrite[3], regwrite[3], pcen[3];
   logic       iord[3], memtoreg[3], regdst[3], link[3], zeroext[3], alusrca[3], illegal[3];
   logic [1:0] alusrcb[3], pcsrc[3];
   logic [2:0] aluop[3];
   logic [3:0] state_o[3];

   always #5 clk = ~clk;

   // dut 0: EXT_OPS=1 MEM_HANDSHAKE=0, dut 1: EXT_OPS=1 MEM_HANDSHAKE=1, dut 2: EXT_OPS=0
   mc_maindec #(.EXT_OPS(1'b1), .MEM_HANDSHAKE(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req[0]), .memwrite(memwrite[0]), .irwrite(irwrite[0]),
      .regwrite(regwrite[0]), .pcen(pcen[0]), .iord(iord[0]), .memtoreg(memtoreg[0]),
      .regdst(regdst[0]), .link(link[0]), .zeroext(zeroext[0]), .alusrca(alusrca[0]),
      .alusrcb(alusrcb[0]), .pcsrc(pcsrc[0]), .aluop(aluop[0]), .state_o(state_o[0]),
      .illegal(illegal[0]));

   mc_maindec #(.EXT_OPS(1'b1), .MEM_HANDSHAKE(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req[1]), .memwrite(memwrite[1]), .irwrite(irwrite[1]),
      .regwrite(regwrite[1]), .pcen(pcen[1]), .iord(iord[1]), .memtoreg(memtoreg[1]),
      .regdst(regdst[1]), .link(link[1]), .zeroext(zeroext[1]), .alusrca(alusrca[1]),
      .alusrcb(alusrcb[1]), .pcsrc(pcsrc[1]), .aluop(aluop[1]), .state_o(state_o[1]),
      .illegal(illegal[1]));

   mc_maindec #(.EXT_OPS(1'b0), .MEM_HANDSHAKE(1'b0)) dut2 (
      .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req[2]), .memwrite(memwrite[2]), .irwrite(irwrite[2]),
      .regwrite(regwrite[2]), .pcen(pcen[2]), .iord(iord[2]), .memtoreg(memtoreg[2]),
      .regdst(regdst[2]), .link(link[2]), .zeroext(zeroext[2]), .alusrca(alusrca[2]),
      .alusrcb(alusrcb[2]), .pcsrc(pcsrc[2]), .aluop(aluop[2]), .state_o(state_o[2]),
      .illegal(illegal[2]));

   // strobes: {mem_req, memwrite, irwrite, regwrite, pcen, illegal}
   // mux:     {iord, memtoreg, regdst, link, zeroext, alusrca, alusrcb, pcsrc, aluop}
   localparam logic [12:0] M_FETCH = 13'b0_0_0_0_0_0_01_00_000;
   localparam logic [12:0] M_DEC   = 13'b0_0_0_0_0_0_11_00_000;
   localparam logic [12:0] M_MADR  = 13'b0_0_0_0_0_1_10_00_000;
   localparam logic [12:0] M_MEM   = 13'b1_0_0_0_0_0_00_00_000;
   localparam logic [12:0] M_MWB   = 13'b0_1_0_0_0_0_00_00_000;
   localparam logic [12:0] M_RT    = 13'b0_0_0_0_0_1_00_00_010;
   localparam logic [12:0] M_AWB   = 13'b0_0_1_0_0_0_00_00_000;
   localparam logic [12:0] M_BR    = 13'b0_0_0_0_0_1_00_01_001;
   localparam logic [12:0] M_ORI   = 13'b0_0_0_0_1_1_10_00_100;
   localparam logic [12:0] M_NONE  = 13'b0_0_0_0_0_0_00_00_000;
   localparam logic [12:0] M_J     = 13'b0_0_0_0_0_0_00_10_000;
   localparam logic [12:0] M_JAL   = 13'b0_0_0_1_0_0_00_10_000;

   localparam logic [5:0] S_FETCH_GO   = 6'b101010;
   localparam logic [5:0] S_FETCH_WAIT = 6'b100000;
   localparam logic [5:0] S_IDLE       = 6'b000000;

   typedef struct {
      int          sel;
      logic [3:0]  st;
      logic [5:0]  stb;
      logic [12:0] mux;
      bit          chk_mux;
      string       name;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;
   event smp_ev;

   task automatic compare_one();
      exp_t        e;
      logic [3:0]  a_st;
      logic [5:0]  a_stb;
      logic [12:0] a_mux;
      int          s;
      e = q.pop_front();
      s = e.sel;
      a_st  = state_o[s];
      a_stb = {mem_req[s], memwrite[s], irwrite[s], regwrite[s], pcen[s], illegal[s]};
      a_mux = {iord[s], memtoreg[s], regdst[s], link[s], zeroext[s], alusrca[s],
               alusrcb[s], pcsrc[s], aluop[s]};
      vectors++;
      if (a_st !== e.st || a_stb !== e.stb || (e.chk_mux && a_mux !== e.mux)) begin
         miscompares++;
         $display("FAIL %s (dut%0d): got state=%0d strobes=%b mux=%b, want state=%0d strobes=%b mux=%b%s",
                  e.name, s, a_st, a_stb, a_mux, e.st, e.stb, e.mux, e.chk_mux ? "" : " (mux ignored)");
      end
   endtask

   // Monitor: one expectation per falling edge, or per explicit mid-cycle sample.
   initial begin
      forever begin
         @(negedge clk or smp_ev);
         if (q.size() > 0) compare_one();
      end
   end

   task automatic cyc(input int sel, input logic [3:0] st, input logic [5:0] stb,
                      input logic [12:0] mux, input string name);
      exp_t e;
      e.sel = sel; e.st = st; e.stb = stb; e.mux = mux; e.chk_mux = 1'b1; e.name = name;
      q.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic push_rst(input int sel, input string name);
      exp_t e;
      e.sel = sel; e.st = 4'd0; e.stb = S_IDLE; e.mux = M_NONE; e.chk_mux = 1'b0; e.name = name;
      q.push_back(e);
   endtask

   task automatic do_reset(input int sel);
      rst_n = 1'b0;
      mem_ready = 1'b1;
      zero = 1'b0;
      push_rst(sel, "reset_hold_a");
      @(posedge clk); #1;
      push_rst(sel, "reset_hold_b");
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; op = 6'b0; zero = 1'b0; mem_ready = 1'b1;
      @(posedge clk); #1;

      // LW, no wait states: 0,1,2,3,4,0
      do_reset(0);
      op = 6'b100011;
      cyc(0, 4'd0, S_FETCH_GO, M_FETCH, "lw_fetch");
      cyc(0, 4'd1, S_IDLE,     M_DEC,   "lw_decode");
      cyc(0, 4'd2, S_IDLE,     M_MADR,  "lw_memadr");
      cyc(0, 4'd3, 6'b100000,  M_MEM,   "lw_memrd");
      cyc(0, 4'd4, 6'b000100,  M_MWB,   "lw_memwb");
      cyc(0, 4'd0, S_FETCH_GO, M_FETCH, "lw_refetch");

      // R-type
      op = 6'b000000;
      cyc(0, 4'd1, S_IDLE,     M_DEC,   "rt_decode");
      cyc(0, 4'd6, S_IDLE,     M_RT,    "rt_exec");
      cyc(0, 4'd7, 6'b000100,  M_AWB,   "rt_aluwb");
      cyc(0, 4'd0, S_FETCH_GO, M_FETCH, "rt_refetch");

      // BEQ taken / not taken
      op = 6'b000100; zero = 1'b1;
      cyc(0, 4'd1, S_IDLE,     M_DEC,   "beq1_decode");
      cyc(0, 4'd8, 6'b000010,  M_BR,    "beq_taken");
      cyc(0, 4'd0, S_FETCH_GO, M_FETCH, "beq1_refetch");
      zero = 1'b0;
      cyc(0, 4'd1, S_IDLE,     M_DEC,   "beq0_decode");
      cyc(0, 4'd8, S_IDLE,     M_BR,    "beq_not_taken");
      cyc(0, 4'd0, S_FETCH_GO, M_FETCH, "beq0_refetch");

      // BNE with zero=1 (not taken) and zero=0 (taken)
      op = 6'b000101; zero = 1'b1;
      cyc(0, 4'd1,  S_IDLE,     M_DEC,   "bne1_decode");
      cyc(0, 4'd12, S_IDLE,     M_BR,    "bne_not_taken");
      cyc(0, 4'd0,  S_FETCH_GO, M_FETCH, "bne1_refetch");
      zero = 1'b0;
      cyc(0, 4'd1,  S_IDLE,     M_DEC,   "bne0_decode");
      cyc(0, 4'd12, 6'b000010,  M_BR,    "bne_taken");
      cyc(0, 4'd0,  S_FETCH_GO, M_FETCH, "bne0_refetch");

      // ORI with extended opcodes
      op = 6'b001101;
      cyc(0, 4'd1,  S_IDLE,     M_DEC,   "ori_decode");
      cyc(0, 4'd9,  S_IDLE,     M_ORI,   "ori_exec");
      cyc(0, 4'd10, 6'b000100,  M_NONE,  "ori_immwb");
      cyc(0, 4'd0,  S_FETCH_GO, M_FETCH, "ori_refetch");

      // JAL then J
      op = 6'b000011;
      cyc(0, 4'd1,  S_IDLE,     M_DEC,   "jal_decode");
      cyc(0, 4'd13, 6'b000110,  M_JAL,   "jal_exec");
      cyc(0, 4'd0,  S_FETCH_GO, M_FETCH, "jal_refetch");
      op = 6'b000010;
      cyc(0, 4'd1,  S_IDLE,     M_DEC,   "j_decode");
      cyc(0, 4'd11, 6'b000010,  M_J,     "j_exec");
      cyc(0, 4'd0,  S_FETCH_GO, M_FETCH, "j_refetch");

      // ORI without extended opcodes: illegal pulse, straight back to FETCH
      do_reset(2);
      op = 6'b001101;
      cyc(2, 4'd0, S_FETCH_GO, M_FETCH, "noext_fetch");
      cyc(2, 4'd1, 6'b000001,  M_DEC,   "noext_illegal");
      cyc(2, 4'd0, S_FETCH_GO, M_FETCH, "noext_refetch");

      // Handshake: FETCH waits twice, SW waits three cycles in MEMWR
      do_reset(1);
      op = 6'b101011;
      mem_ready = 1'b0;
      cyc(1, 4'd0, S_FETCH_WAIT, M_FETCH, "hs_fetch_wait1");
      cyc(1, 4'd0, S_FETCH_WAIT, M_FETCH, "hs_fetch_wait2");
      mem_ready = 1'b1;
      cyc(1, 4'd0, S_FETCH_GO,   M_FETCH, "hs_fetch_ready");
      mem_ready = 1'b0;
      cyc(1, 4'd1, S_IDLE,       M_DEC,   "hs_decode_ignores_ready");
      cyc(1, 4'd2, S_IDLE,       M_MADR,  "hs_memadr_ignores_ready");
      cyc(1, 4'd5, 6'b110000,    M_MEM,   "hs_memwr_wait1");
      cyc(1, 4'd5, 6'b110000,    M_MEM,   "hs_memwr_wait2");
      cyc(1, 4'd5, 6'b110000,    M_MEM,   "hs_memwr_wait3");
      mem_ready = 1'b1;
      cyc(1, 4'd5, 6'b110000,    M_MEM,   "hs_memwr_ready");
      cyc(1, 4'd0, S_FETCH_GO,   M_FETCH, "hs_sw_refetch");

      // Asynchronous reset while in MEMRD
      do_reset(0);
      op = 6'b100011;
      cyc(0, 4'd0, S_FETCH_GO, M_FETCH, "ar_fetch");
      cyc(0, 4'd1, S_IDLE,     M_DEC,   "ar_decode");
      cyc(0, 4'd2, S_IDLE,     M_MADR,  "ar_memadr");
      begin
         exp_t e;
         e.sel = 0; e.st = 4'd3; e.stb = 6'b100000; e.mux = M_MEM; e.chk_mux = 1'b1;
         e.name = "ar_memrd";
         q.push_back(e);
      end
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      push_rst(0, "ar_async_reset");
      ->smp_ev;
      @(posedge clk); #1;
      push_rst(0, "ar_reset_held");
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc(0, 4'd0, S_FETCH_GO, M_FETCH, "ar_first_fetch");
      cyc(0, 4'd1, S_IDLE,     M_DEC,   "ar_decode_again");

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending expectations, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
